// File: rtl/johnson_pkg.sv
// Shared mode encodings and phase-width helper for the Johnson/ring pattern generator.
package johnson_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_PASS    = 2'b01;
  localparam logic [1:0] MODE_JOHNSON = 2'b10;
  localparam logic [1:0] MODE_RING    = 2'b11;

  // Phase must index every state of the longest sequence (Johnson, 2*width states).
  function automatic int ph_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_prescaler.sv
// Step pacing: one step every div+1 enabled cycles; a load restarts the count.
module johnson_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clr,
  output logic             o_step
);

  logic [DIV_W-1:0] r_count;

  // A >= compare makes a lowered divisor take effect on the very next enabled cycle.
  assign o_step = i_ena && (r_count >= i_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_ena) begin
      if (i_clr || o_step) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/johnson_seq_gen.sv
// WIDTH-bit pattern register: hold / pass / Johnson / ring modes, prescaled steps, parallel load.
// Build option JOHNSON_FIX_EN: flags illegal Johnson patterns and clears them on the next step.
module johnson_seq_gen
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIV_W = 8,
  localparam int PH_W  = ph_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  input  logic [DIV_W-1:0] i_div,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tick,
  output logic             o_wrap,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_illegal
);

  localparam logic [PH_W-1:0] JOHNSON_MAX = PH_W'(2 * WIDTH - 1);
  localparam logic [PH_W-1:0] RING_MAX    = PH_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [PH_W-1:0]  r_phase;
  logic             r_tick;
  logic             r_wrap;
  logic [1:0]       r_prevMode;

  logic             w_step;
  logic             w_load;
  logic             w_modeChange;
  logic             w_illegal;
  logic             w_nextWrap;
  logic [WIDTH-1:0] w_nextQ;
  logic [PH_W-1:0]  w_nextPhase;
  logic [PH_W-1:0]  w_phaseMax;

  assign o_load_ready = i_ena;
  assign w_load       = i_load_valid && i_ena;
  assign w_modeChange = (i_mode != r_prevMode);

  johnson_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_ena  (i_ena),
    .i_div  (i_div),
    .i_clr  (w_load),
    .o_step (w_step)
  );

`ifdef JOHNSON_FIX_EN
  logic [PH_W-1:0] w_transCount;

  // The closing edge compares the MSB with the inverted LSB, as the Johnson feedback does.
  always_comb begin
    w_transCount = PH_W'(r_q[WIDTH-1] ~^ r_q[0]);
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_transCount = w_transCount + PH_W'(r_q[i] ^ r_q[i+1]);
    end
  end

  assign w_illegal = (i_mode == MODE_JOHNSON) && (w_transCount > PH_W'(1));
`else
  assign w_illegal = 1'b0;
`endif

  assign o_illegal = w_illegal;

  always_comb begin
    w_nextQ     = r_q;
    w_nextPhase = r_phase;
    w_nextWrap  = 1'b0;
    w_phaseMax  = (i_mode == MODE_JOHNSON) ? JOHNSON_MAX : RING_MAX;
    case (i_mode)
      MODE_PASS:    w_nextQ = i_load_data;
      MODE_JOHNSON: w_nextQ = i_dir ? {~r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      MODE_RING:    w_nextQ = i_dir ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      default:      ;
    endcase
    if ((i_mode == MODE_JOHNSON) || (i_mode == MODE_RING)) begin
      if (i_dir) begin
        if (r_phase == '0) begin
          w_nextPhase = w_phaseMax;
          w_nextWrap  = 1'b1;
        end else begin
          w_nextPhase = r_phase - PH_W'(1);
        end
      end else if (r_phase >= w_phaseMax) begin
        w_nextPhase = '0;
        w_nextWrap  = (r_phase == w_phaseMax);
      end else begin
        w_nextPhase = r_phase + PH_W'(1);
      end
    end
    // Self-correction and mode changes both restart the phase without signalling a wrap.
    if (w_illegal) begin
      w_nextQ     = '0;
      w_nextPhase = '0;
      w_nextWrap  = 1'b0;
    end
    if (w_modeChange) begin
      w_nextPhase = '0;
      w_nextWrap  = 1'b0;
    end
  end

  // Previous mode is captured during reset so the first enabled cycle is not seen as a mode change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q        <= '0;
      r_phase    <= '0;
      r_tick     <= 1'b0;
      r_wrap     <= 1'b0;
      r_prevMode <= i_mode;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (i_ena) begin
        r_prevMode <= i_mode;
        if (w_load) begin
          r_q     <= i_load_data;
          r_phase <= '0;
        end else if (w_step) begin
          r_q     <= w_nextQ;
          r_phase <= w_nextPhase;
          r_tick  <= 1'b1;
          r_wrap  <= w_nextWrap;
        end else if (w_modeChange) begin
          r_phase <= '0;
        end
      end
    end
  end

  assign o_q     = r_q;
  assign o_phase = r_phase;
  assign o_tick  = r_tick;
  assign o_wrap  = r_wrap;

endmodule
